latency_pipe_ctrl: RTL and testbench

//  Flow controller for an N-stage clock-enabled latency register (data width B) in the DDR

---
 rtl/latency_pipe_ctrl.sv | 118 +++++++++++
 tb/tb_latency_pipe_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/latency_pipe_ctrl.sv
// rtl/latency_pipe_ctrl.sv - valid/ready flow controller for an N-stage clock-enabled latency line
// Optional macro LATENCY_PIPE_CTRL_STATS_EN adds stall_cnt/xfer_cnt counter outputs.
module latency_pipe_ctrl #(
  parameter int N = 4,
  parameter int B = 8,
  localparam int OW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [B-1:0]  s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [B-1:0]  m_data,
  output logic          pipe_en,
  output logic [OW-1:0] occupancy,
  output logic          busy,
  output logic          done
`ifdef LATENCY_PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   xfer_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state;
  logic [N-1:0] vld;
  logic [B-1:0] stage [N];
  logic         acc;
  logic         out;

  // Global stall: the whole line freezes while the head beat is refused.
  assign pipe_en = m_ready | ~vld[N-1];
  assign s_ready = pipe_en & (state == RUN);
  assign acc     = s_valid & s_ready;
  assign m_valid = vld[N-1];
  assign out     = m_valid & m_ready;
  assign m_data  = stage[N-1];

  always_ff @(posedge clk) begin
    if (pipe_en) begin
      stage[0] <= s_data;
      for (int i = 1; i < N; i++) stage[i] <= stage[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (pipe_en) begin
      vld[0] <= acc;
      for (int i = 1; i < N; i++) vld[i] <= vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({acc, out})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          // Leave once the last beat is gone, including the cycle it departs.
          if (occupancy == '0 || (occupancy == OW'(1) && out)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LATENCY_PIPE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || (state == IDLE && start)) begin
      stall_cnt <= '0;
      xfer_cnt  <= '0;
    end else if (state != IDLE) begin
      if (m_valid && !m_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (out && xfer_cnt != 32'hFFFF_FFFF) xfer_cnt <= xfer_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_latency_pipe_ctrl.sv
// tb/tb_latency_pipe_ctrl.sv - scoreboard bench for latency_pipe_ctrl with a per-beat age model
module tb_latency_pipe_ctrl;
  localparam int N = 4;
  localparam int B = 8;
  localparam int OW = $clog2(N + 1);
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic clk = 0;
  logic rst, start, flush, s_valid, m_ready;
  logic [B-1:0] s_data;
  logic s_ready, m_valid, pipe_en, busy, done;
  logic [B-1:0] m_data;
  logic [OW-1:0] occupancy;
`ifdef LATENCY_PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt, xfer_cnt;
  int mstall, mxfer;
`endif

  latency_pipe_ctrl #(.N(N), .B(B)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .pipe_en(pipe_en), .occupancy(occupancy), .busy(busy), .done(done)
`ifdef LATENCY_PIPE_CTRL_STATS_EN
    , .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [B-1:0] d;
    int           age;
  } beat_t;

  beat_t q[$];
  int    mst = S_IDLE;
  bit    mdone = 0;
  bit    known = 0;
  int    maxocc = 0;
  int    ndeliv = 0;
  int    passed = 0;
  int    total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Monitor + reference model: a beat becomes visible after N advancing edges.
  always @(negedge clk) begin : mon
    bit mv, pe, sr, acc_m, out_m;
    int occ;
    mv  = (q.size() > 0) && (q[0].age == N);
    pe  = m_ready || !mv;
    sr  = pe && (mst == S_RUN);
    occ = q.size();
    if (known) begin
      chk("m_valid", 32'(m_valid), 32'(mv));
      chk("pipe_en", 32'(pipe_en), 32'(pe));
      chk("s_ready", 32'(s_ready), 32'(sr));
      chk("occupancy", 32'(occupancy), 32'(occ));
      chk("busy", 32'(busy), 32'(mst != S_IDLE));
      chk("done", 32'(done), 32'(mdone));
      if (mv) chk("m_data", 32'(m_data), 32'(q[0].d));
`ifdef LATENCY_PIPE_CTRL_STATS_EN
      chk("stall_cnt", stall_cnt, 32'(mstall));
      chk("xfer_cnt", xfer_cnt, 32'(mxfer));
`endif
    end
    if (rst) begin
      q.delete();
      mst = S_IDLE;
      mdone = 0;
      known = 1;
`ifdef LATENCY_PIPE_CTRL_STATS_EN
      mstall = 0; mxfer = 0;
`endif
    end else begin
      acc_m = s_valid && sr;
      out_m = mv && m_ready;
`ifdef LATENCY_PIPE_CTRL_STATS_EN
      if (mst == S_IDLE && start) begin
        mstall = 0; mxfer = 0;
      end else if (mst != S_IDLE) begin
        if (mv && !m_ready) mstall++;
        if (out_m) mxfer++;
      end
`endif
      mdone = 0;
      case (mst)
        S_IDLE:  if (start) mst = S_RUN;
        S_RUN:   if (flush) mst = S_DRAIN;
        default: if (occ == 0 || (occ == 1 && out_m)) begin
          mst = S_IDLE;
          mdone = 1;
        end
      endcase
      if (pe) begin
        if (out_m) begin
          void'(q.pop_front());
          ndeliv++;
        end
        foreach (q[i]) q[i].age++;
        if (acc_m) q.push_back('{s_data, 1});
      end
      if (q.size() > maxocc) maxocc = q.size();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (mst != S_IDLE && n < 200) begin
      cyc();
      n++;
    end
    chk(nm, 32'(mst), 32'(S_IDLE));
  endtask

  task automatic do_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic do_flush();
    flush = 1; cyc(); flush = 0;
  endtask

  initial begin
    rst = 1; start = 0; flush = 0; s_valid = 0; s_data = '0; m_ready = 1;
    repeat (3) cyc();
    rst = 0;
    cyc();

    // streaming 0x01..0x08 with free downstream
    do_start();
    maxocc = 0; ndeliv = 0;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1; s_data = B'(i); cyc();
    end
    s_valid = 0;
    repeat (8) cyc();
    chk("t1_peak_occ", 32'(maxocc), 32'd4);
    chk("t1_beats", 32'(ndeliv), 32'd8);

    // full pipe held by downstream
    m_ready = 0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1; s_data = B'($urandom); cyc();
    end
    repeat (10) cyc();
    chk("t2_occ", 32'(occupancy), 32'd4);
    chk("t2_pipe_en", 32'(pipe_en), 32'd0);
    s_valid = 0; m_ready = 1;
    repeat (6) cyc();

    // three beats then flush
    ndeliv = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = B'($urandom); cyc();
    end
    s_valid = 0;
    do_flush();
    wait_idle("t3_idle");
    cyc();
    chk("t3_beats", 32'(ndeliv), 32'd3);
    chk("t3_busy", 32'(busy), 32'd0);

    // flush with empty pipe
    do_start();
    do_flush();
    wait_idle("t4_idle");
    cyc();

    // simultaneous accept and deliver every cycle
    do_start();
    s_valid = 1; m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      s_data = B'($urandom); cyc();
    end
    for (int i = 0; i < 20; i++) begin
      s_data = B'($urandom); cyc();
      chk("t5_occ", 32'(occupancy), 32'd4);
    end
    s_valid = 0;
    do_flush();
    wait_idle("t5_idle");

    // reset with beats in flight
    do_start();
    for (int i = 0; i < 3; i++) begin
      s_valid = 1; s_data = B'($urandom); cyc();
    end
    s_valid = 0; rst = 1; cyc(); rst = 0;
    chk("t6_m_valid", 32'(m_valid), 32'd0);
    chk("t6_occ", 32'(occupancy), 32'd0);
    cyc();

    // randomized traffic with sporadic start/flush
    do_start();
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = ($urandom_range(0, 3) != 0);
      s_data  = B'($urandom);
      start   = ($urandom_range(0, 15) == 0);
      flush   = ($urandom_range(0, 60) == 0);
      cyc();
    end
    start = 0; s_valid = 0; m_ready = 1;
    do_flush();
    wait_idle("rand_idle");
    repeat (3) cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
